// File: rtl/simon_fsm_gen.sv
// Simon game controller: LFSR-drawn sequence, timed one-hot playback, edge-by-edge input check.
// Optional idle timeout in S_WAIT is built only when SIMON_TIMEOUT_EN is defined.
module simon_fsm_gen #(
  parameter int          NUM_BTN       = 4,
  parameter int          MAX_LEN       = 16,
  parameter int          SHOW_TICKS    = 4,
  parameter int          GAP_TICKS     = 2,
  parameter int          TIMEOUT_TICKS = 64,
  parameter logic [15:0] SEED          = 16'hACE1,
  localparam int         BTN_W         = (NUM_BTN > 2) ? $clog2(NUM_BTN) : 1,
  localparam int         LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_tick,
  input  logic               reset,
  input  logic               btn_valid,
  input  logic [BTN_W-1:0]   btn_val,
  output logic [NUM_BTN-1:0] led,
  output logic               error_led,
  output logic               win_led,
  output logic [2:0]         state,
  output logic [LEN_W-1:0]   round_cnt,
  output logic [LEN_W-1:0]   init_cnt
);

  // state   | meaning
  // S_INIT  | fill seq_mem from the LFSR, one entry per tick
  // S_PLAY  | show entries 0..round_cnt-1 (lit, then dark gap)
  // S_WAIT  | echo held button on led, wait for a press edge
  // S_CHECK | compare latched guess with seq_mem[input_idx]
  // S_ERROR | wrong guess (or timeout); press restarts
  // S_WIN   | final round completed; press restarts
  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_PLAY  = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_ERROR = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  localparam int IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TICK_MAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TICK_W   = $clog2(TICK_MAX + 1);
  localparam logic [TICK_W-1:0] SHOW_LOAD = TICK_W'(SHOW_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LOAD  = TICK_W'(GAP_TICKS - 1);
  localparam logic [BTN_W:0]    NUM_BTN_X = (BTN_W + 1)'(NUM_BTN);

  if (NUM_BTN < 2 || NUM_BTN > 16 || MAX_LEN < 1 || MAX_LEN > 255 || SHOW_TICKS < 1 ||
      GAP_TICKS < 1 || TIMEOUT_TICKS < 1 || SEED == 16'h0) begin : g_bad_params
    $error("simon_fsm_gen: illegal parameter value");
  end

  state_t             state_q, state_nxt;
  logic [NUM_BTN-1:0] led_nxt;
  logic               error_nxt, win_nxt;
  logic [LEN_W-1:0]   round_nxt, init_nxt;
  logic [LEN_W-1:0]   input_idx, input_idx_nxt;
  logic [LEN_W-1:0]   play_idx, play_idx_nxt, play_idx_inc;
  logic [TICK_W-1:0]  tick_cnt, tick_nxt;
  logic               gap, gap_nxt;
  logic [BTN_W-1:0]   guess, guess_nxt;
  logic               btn_valid_q, press, mem_we;
  logic [15:0]        lfsr;
  logic               lfsr_fb;
  logic [BTN_W:0]     draw_ext;
  logic [BTN_W-1:0]   draw, first_entry;
  logic [BTN_W-1:0]   seq_mem [MAX_LEN];

  function automatic logic [NUM_BTN-1:0] onehot(input logic [BTN_W-1:0] v);
    return NUM_BTN'(1) << v;
  endfunction

  assign lfsr_fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign draw_ext     = {1'b0, lfsr[BTN_W-1:0]};
  assign draw         = (draw_ext >= NUM_BTN_X) ? BTN_W'(draw_ext - NUM_BTN_X) : lfsr[BTN_W-1:0];
  assign press        = btn_valid & ~btn_valid_q;
  assign play_idx_inc = play_idx + LEN_W'(1);
  // with MAX_LEN=1 entry 0 is being written on the same edge that starts playback
  assign first_entry  = (init_cnt == '0) ? draw : seq_mem[0];
  assign state        = state_q;

`ifdef SIMON_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // reloaded outside S_WAIT so every entry starts a full window
  always_ff @(posedge clk_tick or posedge reset) begin
    if (reset)                           idle_cnt <= '0;
    else if (state_q != S_WAIT || press) idle_cnt <= IDLE_W'(TIMEOUT_TICKS - 1);
    else if (idle_cnt != '0)             idle_cnt <= idle_cnt - IDLE_W'(1);
  end
`endif

  always_comb begin
    state_nxt     = state_q;
    led_nxt       = led;
    error_nxt     = error_led;
    win_nxt       = win_led;
    round_nxt     = round_cnt;
    init_nxt      = init_cnt;
    input_idx_nxt = input_idx;
    play_idx_nxt  = play_idx;
    tick_nxt      = tick_cnt;
    gap_nxt       = gap;
    guess_nxt     = guess;
    mem_we        = 1'b0;
    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        led_nxt   = '0;
        error_nxt = 1'b0;
        win_nxt   = 1'b0;
        if (init_cnt == LEN_W'(MAX_LEN - 1)) begin
          state_nxt    = S_PLAY;
          round_nxt    = LEN_W'(1);
          init_nxt     = '0;
          play_idx_nxt = '0;
          tick_nxt     = SHOW_LOAD;
          gap_nxt      = 1'b0;
          led_nxt      = onehot(first_entry);
        end else begin
          init_nxt = init_cnt + LEN_W'(1);
        end
      end
      S_PLAY: begin
        if (tick_cnt != '0) begin
          tick_nxt = tick_cnt - TICK_W'(1);
        end else if (!gap) begin
          gap_nxt  = 1'b1;
          tick_nxt = GAP_LOAD;
          led_nxt  = '0;
        end else if (play_idx == round_cnt - LEN_W'(1)) begin
          state_nxt     = S_WAIT;
          input_idx_nxt = '0;
          led_nxt       = btn_valid ? onehot(btn_val) : '0;
        end else begin
          play_idx_nxt = play_idx_inc;
          gap_nxt      = 1'b0;
          tick_nxt     = SHOW_LOAD;
          led_nxt      = onehot(seq_mem[play_idx_inc[IDX_W-1:0]]);
        end
      end
      S_WAIT: begin
        led_nxt = btn_valid ? onehot(btn_val) : '0;
        if (press) begin
          guess_nxt = btn_val;
          state_nxt = S_CHECK;
        end
`ifdef SIMON_TIMEOUT_EN
        else if (idle_cnt == '0) begin
          state_nxt = S_ERROR;
          error_nxt = 1'b1;
          led_nxt   = '0;
        end
`endif
      end
      S_CHECK: begin
        if (guess != seq_mem[input_idx[IDX_W-1:0]]) begin
          state_nxt = S_ERROR;
          error_nxt = 1'b1;
          led_nxt   = '0;
        end else if (input_idx != round_cnt - LEN_W'(1)) begin
          state_nxt     = S_WAIT;
          input_idx_nxt = input_idx + LEN_W'(1);
          led_nxt       = btn_valid ? onehot(btn_val) : '0;
        end else if (round_cnt == LEN_W'(MAX_LEN)) begin
          state_nxt = S_WIN;
          win_nxt   = 1'b1;
          led_nxt   = '1;
        end else begin
          state_nxt    = S_PLAY;
          round_nxt    = round_cnt + LEN_W'(1);
          play_idx_nxt = '0;
          tick_nxt     = SHOW_LOAD;
          gap_nxt      = 1'b0;
          led_nxt      = onehot(seq_mem[0]);
        end
      end
      S_ERROR: begin
        led_nxt   = '0;
        error_nxt = 1'b1;
        if (press) begin
          state_nxt = S_INIT;
          error_nxt = 1'b0;
          round_nxt = '0;
          init_nxt  = '0;
        end
      end
      S_WIN: begin
        led_nxt = '1;
        win_nxt = 1'b1;
        if (press) begin
          state_nxt = S_INIT;
          win_nxt   = 1'b0;
          round_nxt = '0;
          init_nxt  = '0;
        end
      end
      default: begin
        state_nxt = S_INIT;
        led_nxt   = '0;
        error_nxt = 1'b0;
        win_nxt   = 1'b0;
        round_nxt = '0;
        init_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_tick or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      led         <= '0;
      error_led   <= 1'b0;
      win_led     <= 1'b0;
      round_cnt   <= '0;
      init_cnt    <= '0;
      input_idx   <= '0;
      play_idx    <= '0;
      tick_cnt    <= '0;
      gap         <= 1'b0;
      guess       <= '0;
      btn_valid_q <= 1'b0;
      lfsr        <= SEED;
    end else begin
      state_q     <= state_nxt;
      led         <= led_nxt;
      error_led   <= error_nxt;
      win_led     <= win_nxt;
      round_cnt   <= round_nxt;
      init_cnt    <= init_nxt;
      input_idx   <= input_idx_nxt;
      play_idx    <= play_idx_nxt;
      tick_cnt    <= tick_nxt;
      gap         <= gap_nxt;
      guess       <= guess_nxt;
      btn_valid_q <= btn_valid;
      lfsr        <= {lfsr[14:0], lfsr_fb};
    end
  end

  always_ff @(posedge clk_tick) begin
    if (mem_we) seq_mem[init_cnt[IDX_W-1:0]] <= draw;
  end

endmodule

// File: tb/tb_simon_fsm_gen.sv
// Directed bench for simon_fsm_gen: 4 buttons, 4 rounds, 2-tick show, 1-tick gap, 8-tick timeout.
module tb_simon_fsm_gen;
  localparam int NB = 4, ML = 4, SH = 2, GP = 1, TO = 8;

  logic       clk_tick = 1'b0;
  logic       reset = 1'b1;
  logic       btn_valid = 1'b0;
  logic [1:0] btn_val = 2'd0;
  logic [3:0] led;
  logic       error_led, win_led;
  logic [2:0] state, round_cnt, init_cnt;

  simon_fsm_gen #(
    .NUM_BTN(NB), .MAX_LEN(ML), .SHOW_TICKS(SH), .GAP_TICKS(GP),
    .TIMEOUT_TICKS(TO), .SEED(16'hACE1)
  ) dut (
    .clk_tick(clk_tick), .reset(reset), .btn_valid(btn_valid), .btn_val(btn_val),
    .led(led), .error_led(error_led), .win_led(win_led), .state(state),
    .round_cnt(round_cnt), .init_cnt(init_cnt)
  );

  always #5 clk_tick = ~clk_tick;

  // reference LFSR: Fibonacci, taps 16,14,13,11, free-running from SEED
  logic [15:0] m_lfsr;
  always @(posedge clk_tick or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_seq [ML];

  typedef struct {
    int         seq_idx;
    logic [2:0] exp_state;
    logic [2:0] exp_round;
    logic [2:0] exp_idx;
  } step_t;
  step_t steps [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_tick);
    @(negedge clk_tick);
  endtask

  function automatic logic [3:0] oh(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

  task automatic press_pulse(input logic [1:0] v);
    btn_val   = v;
    btn_valid = 1'b1;
    tick();
    btn_valid = 1'b0;
  endtask

  // called just after entry to S_INIT; records the draws and checks the fill
  task automatic run_init();
    for (int i = 0; i < ML; i++) begin
      exp_seq[i] = m_lfsr[1:0];
      chk("init_state", 32'(state), 32'd0);
      tick();
    end
    chk("play_entry_state", 32'(state), 32'd1);
    chk("play_entry_round", 32'(round_cnt), 32'd1);
    chk("play_entry_init_cnt", 32'(init_cnt), 32'd0);
    for (int i = 0; i < ML; i++) chk("seq_mem", 32'(dut.seq_mem[i]), 32'(exp_seq[i]));
  endtask

  // called just after entry to S_PLAY
  task automatic play_check(input int rounds);
    for (int i = 0; i < rounds; i++) begin
      for (int s = 0; s < SH; s++) begin
        chk("play_led", 32'(led), 32'(oh(exp_seq[i])));
        tick();
      end
      for (int g = 0; g < GP; g++) begin
        chk("gap_led", 32'(led), 32'd0);
        tick();
      end
    end
    chk("wait_entry_state", 32'(state), 32'd2);
  endtask

  initial begin
    int  cur_round;
    bit  in_play;
    int  cnt;
    int  n_check_state;

    steps[0] = '{0, 3'd1, 3'd2, 3'd0};
    steps[1] = '{0, 3'd2, 3'd2, 3'd1};
    steps[2] = '{1, 3'd1, 3'd3, 3'd1};
    steps[3] = '{0, 3'd2, 3'd3, 3'd1};
    steps[4] = '{1, 3'd2, 3'd3, 3'd2};
    steps[5] = '{2, 3'd1, 3'd4, 3'd2};
    steps[6] = '{0, 3'd2, 3'd4, 3'd1};
    steps[7] = '{1, 3'd2, 3'd4, 3'd2};
    steps[8] = '{2, 3'd2, 3'd4, 3'd3};
    steps[9] = '{3, 3'd5, 3'd4, 3'd3};

    // reset held two ticks
    repeat (2) @(posedge clk_tick);
    @(negedge clk_tick);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_round", 32'(round_cnt), 32'd0);
    chk("rst_init_cnt", 32'(init_cnt), 32'd0);
    chk("rst_error_led", 32'(error_led), 32'd0);
    chk("rst_win_led", 32'(win_led), 32'd0);
    reset = 1'b0;
    run_init();

    // full game to the win state
    cur_round = 1;
    in_play   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (in_play) play_check(cur_round);
      press_pulse(exp_seq[steps[k].seq_idx]);
      chk("check_state", 32'(state), 32'd3);
      tick();
      chk("step_state", 32'(state), 32'(steps[k].exp_state));
      chk("step_round", 32'(round_cnt), 32'(steps[k].exp_round));
      chk("step_input_idx", 32'(dut.input_idx), 32'(steps[k].exp_idx));
      cur_round = int'(steps[k].exp_round);
      in_play   = (steps[k].exp_state == 3'd1);
      if (steps[k].exp_state == 3'd5) begin
        chk("win_led", 32'(win_led), 32'd1);
        chk("win_leds_all", 32'(led), 32'hF);
      end
    end
    press_pulse(2'd0);
    chk("win_exit_state", 32'(state), 32'd0);
    chk("win_exit_win_led", 32'(win_led), 32'd0);
    run_init();

    // wrong guess in round 2
    play_check(1);
    press_pulse(exp_seq[0]);
    chk("err_check1", 32'(state), 32'd3);
    tick();
    chk("err_r2_state", 32'(state), 32'd1);
    chk("err_r2_round", 32'(round_cnt), 32'd2);
    play_check(2);
    press_pulse(exp_seq[0]);
    tick();
    chk("err_idx1_state", 32'(state), 32'd2);
    chk("err_idx1", 32'(dut.input_idx), 32'd1);
    press_pulse(exp_seq[1] ^ 2'b01);
    chk("err_check2", 32'(state), 32'd3);
    tick();
    chk("err_state", 32'(state), 32'd4);
    chk("err_error_led", 32'(error_led), 32'd1);
    chk("err_led", 32'(led), 32'd0);
    press_pulse(2'd0);
    chk("err_exit_state", 32'(state), 32'd0);
    chk("err_exit_error_led", 32'(error_led), 32'd0);
    chk("err_exit_round", 32'(round_cnt), 32'd0);
    run_init();

    // press handling: pulse during playback, held button in S_WAIT
    play_check(1);
    press_pulse(exp_seq[0]);
    tick();
    chk("ph_r2_state", 32'(state), 32'd1);
    btn_val   = exp_seq[1];
    btn_valid = 1'b1;
    tick();
    btn_valid = 1'b0;
    chk("pulse_ignored_state", 32'(state), 32'd1);
    cnt = 1;
    while (state != 3'd2 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("pulse_play_len", 32'(cnt), 32'd6);
    chk("pulse_round", 32'(round_cnt), 32'd2);
    chk("pulse_input_idx", 32'(dut.input_idx), 32'd0);
    btn_val       = exp_seq[0];
    btn_valid     = 1'b1;
    n_check_state = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (t == 0) chk("hold_led", 32'(led), 32'(oh(exp_seq[0])));
      if (state == 3'd3) n_check_state++;
    end
    chk("hold_one_check", 32'(n_check_state), 32'd1);
    chk("hold_input_idx", 32'(dut.input_idx), 32'd1);
    chk("hold_state", 32'(state), 32'd2);
    btn_valid = 1'b0;
    tick();
    press_pulse(exp_seq[1]);
    tick();
    chk("r3_state", 32'(state), 32'd1);
    chk("r3_round", 32'(round_cnt), 32'd3);

    // asynchronous reset in the middle of playback
    tick();
    chk("mid_play_led", 32'(led), 32'(oh(exp_seq[0])));
    reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_round", 32'(round_cnt), 32'd0);
    chk("async_rst_init_cnt", 32'(init_cnt), 32'd0);
    tick();
    reset = 1'b0;
    run_init();

    // idle in S_WAIT
    play_check(1);
`ifdef SIMON_TIMEOUT_EN
    for (int t = 0; t < TO - 1; t++) begin
      tick();
      chk("timeout_still_wait", 32'(state), 32'd2);
    end
    tick();
    chk("timeout_state", 32'(state), 32'd4);
    chk("timeout_error_led", 32'(error_led), 32'd1);
`else
    repeat (100) tick();
    chk("no_timeout_state", 32'(state), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/simon_fsm_gen.md
Name: simon_fsm_gen

Overview:
Parametrised successor to the hard-coded Simon game FSM: `N` buttons, sequence up to `MAX_LEN`, sequence generated by an LFSR.
- Plays rounds of growing length on one-hot LEDs with programmable on/off timing.
- Checks player input edge-by-edge; adds a win state and an optional input timeout.
- Sits between the button debouncer (`btn_valid`/`btn_val`) and the board LEDs; clocked by the slow game tick.

Parameters:
- `NUM_BTN`, 4, number of buttons/LEDs (2..16); `BTN_W = max(1, clog2(NUM_BTN))` is derived.
- `MAX_LEN`, 16, longest sequence, i.e. the winning round (1..255); `LEN_W = clog2(MAX_LEN+1)` is derived.
- `SHOW_TICKS`, 4, ticks each LED is lit during playback (>=1).
- `GAP_TICKS`, 2, ticks all LEDs are dark after each playback step (>=1).
- `TIMEOUT_TICKS`, 64, idle ticks in `S_WAIT` before error (only with the optional feature).
- `SEED`, 16'hACE1, LFSR reset value (nonzero).

Ports:
- `clk_tick` input 1: game tick clock.
- `reset` input 1: reset.
- `btn_valid` input 1: debounced button-pressed level.
- `btn_val` input `BTN_W`: index of the pressed button, valid while `btn_valid`=1.
- `led` output `NUM_BTN`: one-hot LED drive.
- `error_led` output 1: high in `S_ERROR`.
- `win_led` output 1: high in `S_WIN`.
- `state` output 3: current FSM state.
- `round_cnt` output `LEN_W`: current round (sequence length being played).
- `init_cnt` output `LEN_W`: sequence-fill index.

Interface (already decided): one clock, `clk_tick`; reset is `reset`, asynchronous and active-high.

Behaviour:
- State encoding: `S_INIT`=0, `S_PLAY`=1, `S_WAIT`=2, `S_CHECK`=3, `S_ERROR`=4, `S_WIN`=5; codes 6 and 7 go to `S_INIT`.
- All outputs are registered and update on the same edge as `state`.
- Reset (async, any time, including mid-round):
  - `state`=`S_INIT`; `led`=0; `error_led`=0; `win_led`=0; `round_cnt`=0; `init_cnt`=0.
  - `input_idx`=0; all tick counters 0; `lfsr`=`SEED`; `btn_valid_q`=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; free-runs every tick in every state.
  - Draw `v = lfsr[BTN_W-1:0]`; stored entry = `v >= NUM_BTN ? v - NUM_BTN : v`.
- Press event: `press = btn_valid & ~btn_valid_q`, where `btn_valid_q` is `btn_valid` delayed one tick.
  - A held button counts as exactly one press.
  - Presses occurring in `S_INIT`, `S_PLAY` and `S_CHECK` are discarded.
- `S_INIT`:
  - Each tick writes `seq_mem[init_cnt]` from the LFSR draw and increments `init_cnt`.
  - After the write at `init_cnt = MAX_LEN-1`: go to `S_PLAY` with `round_cnt`=1, `init_cnt`=0.
  - Total `S_INIT` duration is exactly `MAX_LEN` ticks.
- `S_PLAY`, for step `i` = 0..`round_cnt`-1:
  - `led` = one-hot(`seq_mem[i]`) for `SHOW_TICKS` ticks, then `led`=0 for `GAP_TICKS` ticks.
  - After the gap of step `round_cnt`-1: go to `S_WAIT` with `input_idx`=0.
- `S_WAIT`:
  - `led` = one-hot(`btn_val`) while `btn_valid`=1, else 0.
  - On press: latch `btn_val` into `guess`; next state `S_CHECK`.
- `S_CHECK` (exactly 1 tick):
  - Mismatch (`guess != seq_mem[input_idx]`) -> `S_ERROR`.
  - Match with `input_idx < round_cnt-1` -> `input_idx`+1, `S_WAIT`.
  - Match on the last entry with `round_cnt == MAX_LEN` -> `S_WIN`.
  - Match on the last entry otherwise -> `round_cnt`+1, `S_PLAY`.
- `S_ERROR`: `error_led`=1, `led`=0. On press -> `S_INIT` (new sequence drawn, `round_cnt`=0, `error_led`=0).
- `S_WIN`: `win_led`=1, `led` = all ones. On press -> `S_INIT`, `win_led`=0.
- Latency: press edge sampled at tick T -> `state`=`S_CHECK` at T+1 -> next state at T+2.

Optional Feature:
- Macro: `SIMON_TIMEOUT_EN`.
- Defined:
  - An idle counter clears on entry to `S_WAIT` and on each press, and increments every `S_WAIT` tick.
  - When it reaches `TIMEOUT_TICKS`, the FSM goes to `S_ERROR` on that edge.
  - A press on the same tick as the timeout wins: the FSM goes to `S_CHECK`.
- Undefined: no counter is built; `S_WAIT` waits indefinitely.

Test Plan:
(`NUM_BTN`=4, `MAX_LEN`=4, `SHOW_TICKS`=2, `GAP_TICKS`=1 unless noted; the bench reads `dut.seq_mem`.)
1. Reset held 2 ticks, then released -> `state`=0 for exactly 4 ticks, then `state`=1, `round_cnt`=1; every `seq_mem` entry < 4.
2. Round 1 playback -> `led` = one-hot(`seq_mem[0]`) for 2 ticks, then 0 for 1 tick, then `state`=2.
3. Correct presses for rounds 1-4 -> `S_CHECK` for 1 tick after each press; `round_cnt` reaches 4, then `state`=5 with `win_led`=1 and `led`=4'b1111; one press -> `state`=0, `win_led`=0.
4. Round 2: press `seq_mem[0]`, then a wrong value (`seq_mem[1]`^1) -> `state`=3, then 4 with `error_led`=1; one press -> `state`=0, `error_led`=0, `round_cnt`=0.
5. Press handling:
   - `btn_valid` held for 3 ticks in `S_WAIT` -> exactly one `S_CHECK`, `input_idx` advances by 1.
   - `btn_valid` pulsed during `S_PLAY` -> ignored; `round_cnt` and `input_idx` unchanged.
6. Timeout, `TIMEOUT_TICKS`=8:
   - With `SIMON_TIMEOUT_EN`: 8 idle ticks in `S_WAIT` -> `state`=4.
   - Without it: still `state`=2 after 100 ticks.
   - Also: `reset` asserted mid-`S_PLAY` -> outputs clear immediately, before the next edge.
